// File: rtl/box_overlay.sv
// Rectangle border overlay on a DVI-style video stream.
// Four-stage pipeline with a frame-lock FSM gating the overlay.
module box_overlay #(
  parameter logic [11:0] BOX_X0    = 12'd100,
  parameter logic [11:0] BOX_Y0    = 12'd100,
  parameter logic [11:0] BOX_W     = 12'd200,
  parameter logic [11:0] BOX_H     = 12'd100,
  parameter logic [11:0] THICK     = 12'd2,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic        pixel_clk,
  input  logic        aresetn,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vde_in,
  input  logic [23:0] pixel_in,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out,
  output logic [23:0] pixel_out,
  output logic        frame_locked
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    LOCKED
  } lock_state_t;

  localparam logic [11:0] CMAX = 12'hFFF;

  // Box edges widened to 13 bits so far edges never wrap.
  localparam logic [12:0] XL  = {1'b0, BOX_X0};
  localparam logic [12:0] XR  = XL + {1'b0, BOX_W} - 13'd1;
  localparam logic [12:0] XLI = XL + {1'b0, THICK};
  localparam logic [12:0] XRO = XL + {1'b0, BOX_W};
  localparam logic [12:0] YT  = {1'b0, BOX_Y0};
  localparam logic [12:0] YB  = YT + {1'b0, BOX_H} - 13'd1;
  localparam logic [12:0] YTI = YT + {1'b0, THICK};
  localparam logic [12:0] YBO = YT + {1'b0, BOX_H};
  localparam logic [12:0] TK  = {1'b0, THICK};

  lock_state_t state;

  logic        hs1, vs1, de1;
  logic [23:0] px1;
  logic [11:0] x1, y1;
  logic        hs2, vs2, de2;
  logic [23:0] px2;
  logic        inbox2, edge2;
  logic        hs3, vs3, de3;
  logic [23:0] px3;
  logic        bord3, lk3;

  logic [11:0] x_cnt, y_cnt;
  logic [11:0] first_w;
  logic        have_line, mismatch;

  logic        vs_rise, de_fall, good;
  logic [12:0] xw, yw;
  logic        in_x, in_y, edge_x, edge_y;

  assign vs_rise = vsync_in & ~vs1;
  assign de_fall = ~vde_in & de1;
  assign good    = have_line & ~mismatch;

  assign xw     = {1'b0, x1};
  assign yw     = {1'b0, y1};
  assign in_x   = (xw >= XL) && (xw <= XR);
  assign in_y   = (yw >= YT) && (yw <= YB);
  assign edge_x = (xw < XLI) || ((xw + TK) >= XRO);
  assign edge_y = (yw < YTI) || ((yw + TK) >= YBO);

  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (vde_in)
        x_cnt <= (x_cnt == CMAX) ? x_cnt : x_cnt + 12'd1;
      else if (de_fall)
        x_cnt <= '0;
      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall)
        y_cnt <= (y_cnt == CMAX) ? y_cnt : y_cnt + 12'd1;
    end
  end

  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) begin
      hs1 <= 1'b0; vs1 <= 1'b0; de1 <= 1'b0;
      px1 <= '0; x1 <= '0; y1 <= '0;
      hs2 <= 1'b0; vs2 <= 1'b0; de2 <= 1'b0;
      px2 <= '0; inbox2 <= 1'b0; edge2 <= 1'b0;
      hs3 <= 1'b0; vs3 <= 1'b0; de3 <= 1'b0;
      px3 <= '0; bord3 <= 1'b0; lk3 <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      vde_out   <= 1'b0;
      pixel_out <= '0;
    end else begin
      hs1 <= hsync_in; vs1 <= vsync_in; de1 <= vde_in;
      px1 <= pixel_in; x1 <= x_cnt; y1 <= y_cnt;
      hs2 <= hs1; vs2 <= vs1; de2 <= de1;
      px2 <= px1;
      inbox2 <= in_x & in_y;
      edge2  <= edge_x | edge_y;
      hs3 <= hs2; vs3 <= vs2; de3 <= de2;
      px3 <= px2;
      bord3 <= inbox2 & edge2;
      lk3   <= frame_locked;
      hsync_out <= hs3;
      vsync_out <= vs3;
      vde_out   <= de3;
      pixel_out <= (de3 & lk3 & bord3) ? BOX_COLOR : px3;
    end
  end

  // Line-width statistics restart at every vsync rising edge.
  always_ff @(posedge pixel_clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= SEARCH;
      frame_locked <= 1'b0;
      first_w      <= '0;
      have_line    <= 1'b0;
      mismatch     <= 1'b0;
    end else if (vs_rise) begin
      first_w   <= '0;
      have_line <= 1'b0;
      mismatch  <= 1'b0;
      unique case (state)
        SEARCH: begin
          state        <= ALIGN;
          frame_locked <= 1'b0;
        end
        ALIGN, LOCKED: begin
          state        <= good ? LOCKED : SEARCH;
          frame_locked <= good;
        end
        default: begin
          state        <= SEARCH;
          frame_locked <= 1'b0;
        end
      endcase
    end else if (de_fall) begin
      if (!have_line) begin
        first_w   <= x_cnt;
        have_line <= 1'b1;
      end else if (x_cnt != first_w) begin
        mismatch <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Directed bench for box_overlay: latency, lock, overlay,
// mismatch, mid-frame reset and far-edge clipping.
module tb_box_overlay;

  logic        pixel_clk = 1'b0;
  logic        aresetn;
  logic        hsync_in, vsync_in, vde_in;
  logic [23:0] pixel_in;
  logic        hsync_out, vsync_out, vde_out, frame_locked;
  logic [23:0] pixel_out;
  logic        hs_c, vs_c, de_c, lk_c;
  logic [23:0] px_c;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 pixel_clk = ~pixel_clk;

  box_overlay #(
    .BOX_X0(12'd2), .BOX_Y0(12'd1), .BOX_W(12'd4),
    .BOX_H(12'd3), .THICK(12'd1), .BOX_COLOR(24'hFFFFFF)
  ) dut (
    .pixel_clk(pixel_clk), .aresetn(aresetn),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vde_in(vde_in), .pixel_in(pixel_in),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .vde_out(vde_out), .pixel_out(pixel_out),
    .frame_locked(frame_locked)
  );

  box_overlay #(
    .BOX_X0(12'd4094), .BOX_Y0(12'd0), .BOX_W(12'd4),
    .BOX_H(12'd2), .THICK(12'd1), .BOX_COLOR(24'hFFFFFF)
  ) dut_c (
    .pixel_clk(pixel_clk), .aresetn(aresetn),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vde_in(vde_in), .pixel_in(pixel_in),
    .hsync_out(hs_c), .vsync_out(vs_c),
    .vde_out(de_c), .pixel_out(px_c),
    .frame_locked(lk_c)
  );

  // Output frame capture for the small-box instance.
  logic [23:0] cap [4][8];
  int          mr, mc, ncol;
  logic        m_vs, m_de;

  always @(negedge pixel_clk) begin
    m_vs <= vsync_out;
    m_de <= vde_out;
    if (vsync_out && !m_vs) begin
      mr <= 0; mc <= 0; ncol <= 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 8; j++)
          cap[i][j] <= 24'h5A5A5A;
    end else if (vde_out) begin
      if (mr < 4 && mc < 8) cap[mr][mc] <= pixel_out;
      if (pixel_out != 24'h0) ncol <= ncol + 1;
      mc <= mc + 1;
    end else if (m_de) begin
      mr <= mr + 1;
      mc <= 0;
    end
  end

  // Colored-pixel census for the clipped instance.
  int   ccnt, ccol;
  logic cbad, c_vs;

  always @(negedge pixel_clk) begin
    c_vs <= vs_c;
    if (vs_c && !c_vs) begin
      ccnt <= 0; ccol <= 0; cbad <= 1'b0;
    end else if (de_c) begin
      if (px_c != 24'h0) begin
        ccnt <= ccnt + 1;
        if (ccol != 4094 && ccol != 4095) cbad <= 1'b1;
      end
      ccol <= ccol + 1;
    end else begin
      ccol <= 0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle(input int n);
    hsync_in = 1'b0; vsync_in = 1'b0;
    vde_in = 1'b0; pixel_in = 24'h0;
    repeat (n) tick();
  endtask

  task automatic line(input int w);
    hsync_in = 1'b1; tick();
    hsync_in = 1'b0; tick(); tick();
    vde_in = 1'b1;
    repeat (w) tick();
    vde_in = 1'b0; tick();
  endtask

  task automatic preamble();
    vsync_in = 1'b1; tick(); tick();
    vsync_in = 1'b0; tick(); tick();
  endtask

  task automatic body(input int w2);
    for (int r = 0; r < 4; r++) line(r == 2 ? w2 : 8);
    idle(5);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle(3);
    aresetn = 1'b1;
    idle(2);
  endtask

  function automatic logic [31:0] out_of(input int k);
    case (k)
      0: return {31'b0, hsync_out};
      1: return {31'b0, vsync_out};
      2: return {31'b0, vde_out};
      default: return {8'b0, pixel_out};
    endcase
  endfunction

  task automatic lat(input int k);
    logic [31:0] want;
    want = (k == 3) ? 32'hA5C33C : 32'h1;
    case (k)
      0: hsync_in = 1'b1;
      1: vsync_in = 1'b1;
      2: vde_in = 1'b1;
      default: pixel_in = 24'hA5C33C;
    endcase
    tick();
    idle(0);
    tick(); tick();
    check($sformatf("lat%0d_c3", k), out_of(k), 32'h0);
    tick();
    check($sformatf("lat%0d_c4", k), out_of(k), want);
    tick();
    check($sformatf("lat%0d_c5", k), out_of(k), 32'h0);
    idle(3);
  endtask

  task automatic check_overlay(input string tag);
    logic [7:0] exp_mask [4];
    logic [7:0] mask;
    int         odd;
    exp_mask = '{8'h00, 8'h3C, 8'h24, 8'h3C};
    for (int r = 0; r < 4; r++) begin
      mask = 8'h0;
      odd  = 0;
      for (int c = 0; c < 8; c++) begin
        mask[c] = (cap[r][c] == 24'hFFFFFF);
        if (cap[r][c] != 24'hFFFFFF && cap[r][c] != 24'h0)
          odd++;
      end
      check($sformatf("%s_row%0d", tag, r), {24'b0, mask},
            {24'b0, exp_mask[r]});
      check($sformatf("%s_odd%0d", tag, r), odd, 0);
    end
    check($sformatf("%s_ncol", tag), ncol, 10);
  endtask

  initial begin
    aresetn = 1'b0;
    idle(0);
    tick();
    check("rst_hs", {31'b0, hsync_out}, 0);
    check("rst_vs", {31'b0, vsync_out}, 0);
    check("rst_de", {31'b0, vde_out}, 0);
    check("rst_px", {8'b0, pixel_out}, 0);
    check("rst_lk", {31'b0, frame_locked}, 0);
    aresetn = 1'b1;
    idle(2);

    for (int k = 0; k < 4; k++) lat(k);
    check("lat_unlocked", {31'b0, frame_locked}, 0);

    do_reset();
    preamble();
    check("f1_lk", {31'b0, frame_locked}, 0);
    body(8);
    check("f1_black", ncol, 0);
    check("f1_cap", {8'b0, cap[3][7]}, 0);
    preamble();
    check("f2_lk", {31'b0, frame_locked}, 1);
    body(8);
    check("f2_ncol", ncol, 10);
    preamble();
    check("f3_lk", {31'b0, frame_locked}, 1);
    body(8);
    check_overlay("f3");

    preamble();
    check("mm_lk_pre", {31'b0, frame_locked}, 1);
    body(7);
    preamble();
    check("mm_drop", {31'b0, frame_locked}, 0);
    body(8);
    check("mm_black", ncol, 0);
    preamble();
    check("mm_align", {31'b0, frame_locked}, 0);
    body(8);
    preamble();
    check("mm_relock", {31'b0, frame_locked}, 1);
    body(8);
    check_overlay("relock");

    preamble();
    line(8);
    line(8);
    hsync_in = 1'b1; tick();
    hsync_in = 1'b0; tick(); tick();
    vde_in = 1'b1;
    tick(); tick(); tick();
    check("mid_lk_pre", {31'b0, frame_locked}, 1);
    aresetn = 1'b0;
    #1;
    check("mid_hs", {31'b0, hsync_out}, 0);
    check("mid_vs", {31'b0, vsync_out}, 0);
    check("mid_de", {31'b0, vde_out}, 0);
    check("mid_px", {8'b0, pixel_out}, 0);
    check("mid_lk", {31'b0, frame_locked}, 0);
    idle(3);
    aresetn = 1'b1;
    idle(3);
    preamble();
    check("mid_f1_lk", {31'b0, frame_locked}, 0);
    body(8);
    check("mid_f1_black", ncol, 0);
    preamble();
    check("mid_f2_lk", {31'b0, frame_locked}, 1);
    body(8);
    check_overlay("mid_f2");

    do_reset();
    for (int f = 1; f <= 3; f++) begin
      preamble();
      vde_in = 1'b0;
      for (int r = 0; r < 2; r++) line(4096);
      idle(6);
      if (f == 1) check("clip_f1_black", ccnt, 0);
    end
    check("clip_lk", {31'b0, lk_c}, 1);
    check("clip_ncol", ccnt, 4);
    check("clip_cols", {31'b0, cbad}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/box_overlay.md
BOX_OVERLAY -- requirements
Module: box_overlay

Interface
REQ-001 SHALL have parameter BOX_X0, default 12'd100: left column of the rectangle in active pixels.
REQ-002 SHALL have parameter BOX_Y0, default 12'd100: top row of the rectangle in active lines.
REQ-003 SHALL have parameter BOX_W, default 12'd200: rectangle width in pixels, legal range 1..4095.
REQ-004 SHALL have parameter BOX_H, default 12'd100: rectangle height in lines, legal range 1..4095.
REQ-005 SHALL have parameter THICK, default 12'd2: border thickness in pixels and lines, legal range 1..min(BOX_W,BOX_H).
REQ-006 SHALL have parameter BOX_COLOR, default 24'hFF0000: 24-bit RGB value written onto border pixels.
REQ-007 SHALL have port pixel_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-008 SHALL have port aresetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 SHALL have port hsync_in, input, 1 bit: horizontal sync, active-high.
REQ-010 SHALL have port vsync_in, input, 1 bit: vertical sync, active-high.
REQ-011 SHALL have port vde_in, input, 1 bit: video data enable, high during active pixels.
REQ-012 SHALL have port pixel_in, input, 24 bits: pixel in RGB order, [23:16]=R.
REQ-013 SHALL have port hsync_out, output, 1 bit: hsync_in delayed by 4 cycles.
REQ-014 SHALL have port vsync_out, output, 1 bit: vsync_in delayed by 4 cycles.
REQ-015 SHALL have port vde_out, output, 1 bit: vde_in delayed by 4 cycles.
REQ-016 SHALL have port pixel_out, output, 24 bits: pixel after overlay, delayed by 4 cycles.
REQ-017 SHALL have port frame_locked, output, 1 bit: high while the lock FSM is in LOCKED.

Function
REQ-018 SHALL give hsync, vsync, vde and pixel exactly 4 cycles of latency with no bubbles, so each output sample is aligned with the input sample it came from.
REQ-019 SHALL hold a 12-bit column counter x that increments on every cycle with vde_in=1, saturates at 4095, and clears to 0 on the cycle after a vde_in falling edge.
REQ-020 SHALL hold a 12-bit row counter y that increments on each vde_in falling edge, saturates at 4095, and clears to 0 on a vsync_in rising edge.
REQ-021 SHALL clear y and take the increment on the next line when a vsync rising edge and a vde falling edge occur in the same cycle; vsync takes priority.
REQ-022 SHALL give each active pixel the coordinate (x,y) equal to the number of active pixels before it in its line and the number of completed lines before it in its frame.
REQ-023 SHALL treat a pixel as a border pixel when all of the following hold:
- BOX_X0<=x<=BOX_X0+BOX_W-1 and BOX_Y0<=y<=BOX_Y0+BOX_H-1;
- and at least one of: x<BOX_X0+THICK, x>BOX_X0+BOX_W-1-THICK, y<BOX_Y0+THICK, y>BOX_Y0+BOX_H-1-THICK.
REQ-024 SHALL compute border comparisons at 13-bit width so that rectangle edges beyond 4095 never wrap.
REQ-025 SHALL set pixel_out=BOX_COLOR when the delayed vde=1, frame_locked=1 and the pixel is a border pixel; otherwise pixel_out SHALL equal the delayed pixel_in, including blanking samples.
REQ-026 SHALL run a lock FSM with states SEARCH, ALIGN and LOCKED.
REQ-027 SHALL move SEARCH->ALIGN on a vsync_in rising edge.
REQ-028 SHALL move ALIGN->LOCKED on the next vsync_in rising edge when the frame just ended had at least one active line and a consistent line width.
REQ-029 SHALL move ALIGN->SEARCH on the next vsync_in rising edge when that condition fails.
REQ-030 SHALL latch the first line's width each frame and set a mismatch flag if any later line's width differs.
REQ-031 SHALL move LOCKED->SEARCH on a vsync_in rising edge when the mismatch flag is set or the frame had zero active lines.
REQ-032 SHALL update frame_locked in the same cycle as the FSM state changes; the overlay decision SHALL use frame_locked as sampled at pipeline stage 3.

Reset
REQ-033 SHALL force on aresetn=0, asynchronously: all pipeline registers, hsync_out, vsync_out, vde_out and pixel_out to 0; x and y to 0; the FSM to SEARCH; frame_locked to 0; the mismatch flag to 0.
REQ-034 SHALL start counting after release only from the next vsync rising edge, treating any partial frame as SEARCH.
REQ-035 SHALL force outputs to 0 within the same cycle when reset is asserted mid-frame, and lock SHALL then take two full vsync periods again.

Verification (params X0=2, Y0=1, W=4, H=3, THICK=1, COLOR=FFFFFF; 8x4 active frame, input pixel 000000)
REQ-036 SHALL check latency: a single-cycle pulse on each of hsync_in, vsync_in, vde_in and pixel_in appears on the corresponding output exactly 4 cycles later, unchanged, while unlocked.
REQ-037 SHALL check lock: send three identical frames; frame_locked rises at the 2nd vsync rising edge and stays high, and frame 1 output is all 000000.
REQ-038 SHALL check the overlay: in frame 3, FFFFFF appears at row 1 x2..5, row 2 x2 and x5, and row 3 x2..5; all other pixels are 000000 (10 border pixels).
REQ-039 SHALL check mismatch: a locked frame with line 2 of 7 pixels drops frame_locked to 0 at the following vsync edge, then it relocks after two good frames.
REQ-040 SHALL check reset mid-frame: drop aresetn at row 2 x3; all outputs are 0 immediately and frame_locked=0, and after release the lock sequence behaves as in REQ-037.
REQ-041 SHALL check clipping: with X0=4094, W=4 the border covers only x=4094..4095 and no other column is colored.
